// File: rtl/bnorm_pkg.sv
// Shared types and widths for the batch-normalize channel sequencer.
package bnorm_pkg;

  localparam int DATA_W  = 16;
  localparam int PARAM_W = 12;
  localparam int OUT_W   = 12;
  localparam int FRAC_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PCAP,
    S_LOAD,
    S_APPLY,
    S_WAIT,
    S_EMIT
  } bnorm_seq_state_t;

endpackage

// File: rtl/bnorm_seq.sv
// Channel sequencer/initiator for bnorm: fetches theta/phi, loads data, returns result.
// Optional BNORM_SEQ_BINARIZE_EN adds out_bit (1 iff result != 0).
module bnorm_seq
  import bnorm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               param_rd,
  output logic [CH_W-1:0]    param_addr,
  input  logic [PARAM_W-1:0] param_theta,
  input  logic [PARAM_W-1:0] param_phi,
  output logic               bn_ready,
  output logic [DATA_W-1:0]  bn_data,
  output logic [PARAM_W-1:0] bn_theta,
  output logic [PARAM_W-1:0] bn_phi,
  input  logic               bn_finish,
  input  logic [OUT_W-1:0]   bn_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CH_W-1:0]    out_ch,
`ifdef BNORM_SEQ_BINARIZE_EN
  output logic               out_bit,
`endif
  output logic               out_last
);

  bnorm_seq_state_t   r_state;
  logic [CH_W-1:0]    r_ch;
  logic               r_busy;
  logic               r_done;
  logic               r_in_ready;
  logic               r_param_rd;
  logic               r_bn_ready;
  logic [DATA_W-1:0]  r_bn_data;
  logic [PARAM_W-1:0] r_bn_theta;
  logic [PARAM_W-1:0] r_bn_phi;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_last;
`ifdef BNORM_SEQ_BINARIZE_EN
  logic               r_out_bit;
`endif

  logic w_last;
  assign w_last = (r_ch == CH_W'(NUM_CH - 1));

  // r_done gate keeps a start coinciding with done from relaunching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_param_rd  <= 1'b0;
      r_bn_ready  <= 1'b0;
      r_bn_data   <= '0;
      r_bn_theta  <= '0;
      r_bn_phi    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
`ifdef BNORM_SEQ_BINARIZE_EN
      r_out_bit   <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_param_rd <= 1'b0;
      r_bn_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_ch       <= '0;
            r_busy     <= 1'b1;
            r_param_rd <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_PCAP;
        S_PCAP: begin
          r_bn_theta <= param_theta;
          r_bn_phi   <= param_phi;
          r_in_ready <= 1'b1;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          if (in_valid && r_in_ready) begin
            r_bn_data  <= in_data;
            r_in_ready <= 1'b0;
            r_bn_ready <= 1'b1;
            r_state    <= S_APPLY;
          end
        end
        S_APPLY: r_state <= S_WAIT;
        S_WAIT: begin
          if (bn_finish) begin
            r_out_data  <= bn_out;
`ifdef BNORM_SEQ_BINARIZE_EN
            r_out_bit   <= |bn_out;
`endif
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ch    <= '0;
              r_state <= S_IDLE;
            end else begin
              r_ch       <= r_ch + CH_W'(1);
              r_param_rd <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign in_ready   = r_in_ready;
  assign param_rd   = r_param_rd;
  assign param_addr = r_ch;
  assign bn_ready   = r_bn_ready;
  assign bn_data    = r_bn_data;
  assign bn_theta   = r_bn_theta;
  assign bn_phi     = r_bn_phi;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ch     = r_ch;
  assign out_last   = r_out_last;
`ifdef BNORM_SEQ_BINARIZE_EN
  assign out_bit    = r_out_bit;
`endif

endmodule

// File: tb/tb_bnorm_seq.sv
// Directed bench for bnorm_seq with a parameter memory and a bnorm stand-in.
// Build with BNORM_SEQ_BINARIZE_EN to also check out_bit.
module tb_bnorm_seq;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        param_rd;
  logic [CH_W-1:0] param_addr;
  logic [11:0] param_theta, param_phi;
  logic        bn_ready;
  logic [15:0] bn_data;
  logic [11:0] bn_theta, bn_phi;
  logic        bn_finish;
  logic [11:0] bn_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [CH_W-1:0] out_ch;
  logic        out_last;
`ifdef BNORM_SEQ_BINARIZE_EN
  logic        out_bit;
`endif

  int n_chk = 0;
  int n_err = 0;
  int bnr_cnt = 0;
  int done_cnt = 0;

  logic [11:0] th_mem [NUM_CH];
  logic [11:0] ph_mem [NUM_CH];
  logic [2:0]  bn_dly;

  always #5 clk = ~clk;

  bnorm_seq #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .param_rd(param_rd), .param_addr(param_addr),
    .param_theta(param_theta), .param_phi(param_phi),
    .bn_ready(bn_ready), .bn_data(bn_data), .bn_theta(bn_theta),
    .bn_phi(bn_phi), .bn_finish(bn_finish), .bn_out(bn_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch),
`ifdef BNORM_SEQ_BINARIZE_EN
    .out_bit(out_bit),
`endif
    .out_last(out_last)
  );

  always_ff @(posedge clk) begin
    if (param_rd) begin
      param_theta <= th_mem[param_addr];
      param_phi   <= ph_mem[param_addr];
    end
  end

  // bnorm stand-in: y = relu(d*theta >> 8 + phi), sticky finish
  function automatic logic [11:0] bn_f(logic [15:0] d, logic [11:0] t,
                                       logic [11:0] p);
    int y;
    y = (int'($signed(d)) * int'($signed(t))) >>> 8;
    y = y + int'($signed(p));
    if (y < 0) y = 0;
    if (y > 2047) y = 2047;
    return y[11:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bn_finish <= 1'b0;
      bn_out    <= '0;
      bn_dly    <= '0;
    end else begin
      if (bn_ready) begin
        bn_out <= bn_f(bn_data, bn_theta, bn_phi);
        bn_dly <= 3'd3;
      end else if (bn_dly != 0) begin
        bn_dly <= bn_dly - 3'd1;
      end
      if (bn_dly == 3'd1) bn_finish <= 1'b1;
    end
  end

  always @(posedge clk) begin
    bnr_cnt  <= bnr_cnt + int'(bn_ready);
    done_cnt <= done_cnt + int'(done);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_ch(input logic [15:0] d, input int lst, input int ost,
                       input logic [11:0] eo, input logic [11:0] eth,
                       input logic [11:0] eph, input logic [CH_W-1:0] ech,
                       input logic el);
    int n;
    int br0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", in_ready, 1);
    br0 = bnr_cnt;
    repeat (lst) @(negedge clk);
    if (lst > 0) begin
      check("ld_stall_bnr", bnr_cnt, br0);
      check("ld_stall_rdy", in_ready, 1);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    check("bn_ready", bn_ready, 1);
    check("bn_data", bn_data, d);
    check("bn_theta", bn_theta, eth);
    check("bn_phi", bn_phi, eph);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid", out_valid, 1);
    check("out_data", out_data, eo);
    check("out_ch", out_ch, ech);
    check("out_last", out_last, el);
`ifdef BNORM_SEQ_BINARIZE_EN
    check("out_bit", out_bit, (eo != 0));
`endif
    repeat (ost) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, eo);
      check("hold_ch", out_ch, ech);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic frame_end(input int br0, input int dn0);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("bnr_per_ch", bnr_cnt - br0, NUM_CH);
    pulse_start();
    check("start_in_done", busy, 0);
    check("done_pulse", done, 0);
    check("done_cnt", done_cnt - dn0, 1);
  endtask

  initial begin
    int br0;
    int dn0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_outs", {done, in_ready, param_rd, bn_ready, out_valid,
                       out_last}, 0);
    check("rst_data", {bn_data, bn_theta, bn_phi, out_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // frame 1: basic two-channel pass plus start while busy
    th_mem[0] = 12'h100; ph_mem[0] = 12'h000;
    th_mem[1] = 12'h080; ph_mem[1] = 12'h040;
    br0 = bnr_cnt; dn0 = done_cnt;
    pulse_start();
    check("f1_busy", busy, 1);
    check("f1_rd", param_rd, 1);
    check("f1_addr", param_addr, 0);
    pulse_start();
    do_ch(16'h0280, 0, 0, 12'h280, 12'h100, 12'h000, 0, 0);
    do_ch(16'h0100, 0, 0, 12'h0C0, 12'h080, 12'h040, 1, 1);
    frame_end(br0, dn0);

    // frame 2: negative input clamps to zero, load and emit stalls
    th_mem[0] = 12'h100; ph_mem[0] = 12'h000;
    th_mem[1] = 12'h200; ph_mem[1] = 12'h010;
    br0 = bnr_cnt; dn0 = done_cnt;
    pulse_start();
    do_ch(16'hFF00, 5, 4, 12'h000, 12'h100, 12'h000, 0, 0);
    do_ch(16'h0180, 0, 0, 12'h310, 12'h200, 12'h010, 1, 1);
    frame_end(br0, dn0);

    // frame 3: reset during WAIT of channel 1, then restart
    th_mem[0] = 12'h100; ph_mem[0] = 12'h000;
    th_mem[1] = 12'h080; ph_mem[1] = 12'h040;
    dn0 = done_cnt;
    pulse_start();
    do_ch(16'h0280, 0, 0, 12'h280, 12'h100, 12'h000, 0, 0);
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_outs", {in_ready, param_rd, bn_ready, out_valid, out_last,
                        out_ch}, 0);
    check("arst_data", {bn_data, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_nodone", done_cnt - dn0, 0);
    br0 = bnr_cnt; dn0 = done_cnt;
    pulse_start();
    check("rs_rd", param_rd, 1);
    check("rs_addr", param_addr, 0);
    do_ch(16'h0280, 0, 0, 12'h280, 12'h100, 12'h000, 0, 0);
    do_ch(16'h0100, 0, 0, 12'h0C0, 12'h080, 12'h040, 1, 1);
    frame_end(br0, dn0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
